// File: rtl/walk_service_ctrl_pkg.sv
// Shared types and defaults for the pedestrian walk-service controller.
// Imported by the interface, the phase counter and the top-level FSM.
package walk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WALK,
    FLASH,
    DONE
  } walk_state_e;

  localparam int WALK_TICKS_DEF  = 7;
  localparam int FLASH_TICKS_DEF = 5;

endpackage

// File: rtl/walk_service_ctrl_if.sv
// Handshake bundle between the walk-request register, the main traffic FSM
// and the pedestrian service controller.
interface walk_service_ctrl_if;

  logic pending_walk;
  logic tick;
  logic road_clear;
  logic walk_req;
  logic walk_clear;
  logic walk_light;
  logic dont_walk_light;
  logic walk_done;

  modport slave (
    input  pending_walk, tick, road_clear,
    output walk_req, walk_clear, walk_light, dont_walk_light, walk_done
  );

  modport master (
    output pending_walk, tick, road_clear,
    input  walk_req, walk_clear, walk_light, dont_walk_light, walk_done
  );

endinterface

// File: rtl/walk_service_ctrl_tick_down_counter.sv
// Loadable down-counter that steps once per enabled tick and holds at zero.
// One instance times both the WALK and the flashing DON'T-WALK phases.
module tick_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             tickEn_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A load beats a tick; the count saturates at zero so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (tickEn_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/walk_service_ctrl.sv
// Pedestrian-side FSM: requests a traffic stop, runs WALK and flashing
// DON'T-WALK on the 1 Hz tick, and pulses the request-register clear.
module walk_service_ctrl
  import walk_pkg::*;
#(
  parameter int WALK_TICKS  = WALK_TICKS_DEF,
  parameter int FLASH_TICKS = FLASH_TICKS_DEF,
  parameter int CNT_W       = 4
) (
  input logic               clk,
  input logic               reset,
  walk_service_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TICKS - 1);

  walk_state_e state_q;
  logic        walkReq_q;
  logic        walkClear_q;
  logic        walkLight_q;
  logic        dontWalk_q;
  logic        walkDone_q;

  logic             inService;
  logic             abort;
  logic             grant;
  logic             phaseTick;
  logic             cntZero;
  logic             cntLoad;
  logic [CNT_W-1:0] cntLoadVal;

  assign inService  = (state_q == WALK) || (state_q == FLASH);
  assign abort      = inService && !bus.road_clear;
  assign grant      = (state_q == REQUEST) && bus.road_clear;
  // Ticks only count in WALK/FLASH, and never on the cycle of an abort.
  assign phaseTick  = inService && bus.road_clear && bus.tick;
  assign cntLoad    = grant || ((state_q == WALK) && phaseTick && cntZero);
  assign cntLoadVal = grant ? WALK_LOAD : FLASH_LOAD;

  tick_down_counter #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load_i   (cntLoad),
    .loadVal_i(cntLoadVal),
    .tickEn_i (phaseTick),
    .zero_o   (cntZero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      walkReq_q   <= 1'b0;
      walkClear_q <= 1'b0;
      walkLight_q <= 1'b0;
      dontWalk_q  <= 1'b1;
      walkDone_q  <= 1'b0;
    end else begin
      walkClear_q <= 1'b0;
      walkDone_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.pending_walk) begin
            state_q   <= REQUEST;
            walkReq_q <= 1'b1;
          end
        end
        REQUEST: begin
          if (grant) begin
            state_q     <= WALK;
            walkClear_q <= 1'b1;
            walkLight_q <= 1'b1;
            dontWalk_q  <= 1'b0;
          end
        end
        WALK: begin
          if (abort) begin
            state_q     <= IDLE;
            walkReq_q   <= 1'b0;
            walkLight_q <= 1'b0;
            dontWalk_q  <= 1'b1;
          end else if (phaseTick && cntZero) begin
            state_q     <= FLASH;
            walkLight_q <= 1'b0;
            dontWalk_q  <= 1'b1;
          end
        end
        FLASH: begin
          if (abort) begin
            state_q    <= IDLE;
            walkReq_q  <= 1'b0;
            dontWalk_q <= 1'b1;
          end else if (phaseTick) begin
            if (cntZero) begin
              state_q    <= DONE;
              walkReq_q  <= 1'b0;
              dontWalk_q <= 1'b1;
              walkDone_q <= 1'b1;
            end else begin
              dontWalk_q <= ~dontWalk_q;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.walk_req        = walkReq_q;
  assign bus.walk_clear      = walkClear_q;
  assign bus.walk_light      = walkLight_q;
  assign bus.dont_walk_light = dontWalk_q;
  assign bus.walk_done       = walkDone_q;

endmodule

// File: tb/tb_walk_service_ctrl.sv
// Scoreboard bench: stimulus queues each expected output-vector change with the
// number of cycles the previous vector should have lasted; a monitor compares.
module tb_walk_service_ctrl;

  typedef struct {
    logic [4:0] vec;
    int         dwell;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  exp_t expQ[$];

  walk_service_ctrl_if bus ();

  walk_service_ctrl #(
    .WALK_TICKS (3),
    .FLASH_TICKS(2),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector order: {walk_req, walk_clear, walk_light, dont_walk_light, walk_done}
  function automatic logic [4:0] outVec();
    return {bus.walk_req, bus.walk_clear, bus.walk_light,
            bus.dont_walk_light, bus.walk_done};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [4:0] vec, input int dwell);
    expQ.push_back('{vec, dwell});
  endtask

  task automatic applyStimulus(input logic pw, input logic rc, input logic tk, input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      bus.pending_walk = pw;
      bus.road_clear   = rc;
      bus.tick         = tk;
    end
  endtask

  task automatic tickGroup(input logic pw, input logic rc);
    applyStimulus(pw, rc, 1'b0, 3);
    applyStimulus(pw, rc, 1'b1, 1);
  endtask

  // Runs from the first WALK cycle through DONE and back to IDLE.
  task automatic servicePhases(input logic flashPush);
    pushExp(5'b10100, 1);
    pushExp(5'b10010, 11);
    pushExp(5'b10000, 4);
    pushExp(5'b00011, 4);
    pushExp(5'b00010, 1);
    if (flashPush) pushExp(5'b10010, 1);
    repeat (3) tickGroup(1'b0, 1'b1);
    repeat (2) tickGroup(flashPush, 1'b1);
    applyStimulus(flashPush, 1'b1, 1'b0, 2);
  endtask

  // Monitor: compares every change of the output vector with the scoreboard.
  initial begin : monitor
    logic [4:0] lastVec;
    logic [4:0] cur;
    int         sinceChange;
    exp_t       e;
    lastVec     = 5'b00010;
    sinceChange = 0;
    forever begin
      @(negedge clk);
      cur = outVec();
      if (cur != lastVec) begin
        if (expQ.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected_change: got %0b, expected no change from %0b",
                   cur, lastVec);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_vec", int'(cur), int'(e.vec));
          if (e.dwell != 0) checkOutput("dwell_cycles", sinceChange, e.dwell);
        end
        lastVec     = cur;
        sinceChange = 1;
      end else begin
        sinceChange++;
      end
    end
  end

  initial begin : stimulus
    tests  = 0;
    failed = 0;
    bus.pending_walk = 1'b0;
    bus.road_clear   = 1'b0;
    bus.tick         = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 checkOutput("reset_vec", int'(outVec()), 5'b00010);
    repeat (2) @(negedge clk);
    #3 reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2);

    // Request held without a clear road, then granted on a tick cycle.
    pushExp(5'b10010, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    repeat (5) tickGroup(1'b1, 1'b0);
    pushExp(5'b11100, 21);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    servicePhases(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);

    // Plain full service.
    pushExp(5'b10010, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    pushExp(5'b11100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    servicePhases(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);

    // New push during FLASH is served after one IDLE cycle.
    pushExp(5'b10010, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    pushExp(5'b11100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    servicePhases(1'b1);

    // Road clear drops on the 2nd WALK tick: abort to IDLE, no done pulse.
    pushExp(5'b11100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    pushExp(5'b10100, 1);
    pushExp(5'b00010, 7);
    tickGroup(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);

    // Asynchronous reset in the middle of WALK.
    pushExp(5'b10010, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    pushExp(5'b11100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    pushExp(5'b10100, 1);
    pushExp(5'b00010, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 2);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 checkOutput("async_reset_vec", int'(outVec()), 5'b00010);
    @(negedge clk);
    #3 reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    pushExp(5'b10010, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    pushExp(5'b11100, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    servicePhases(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
